// File: rtl/ud_counter_pkg.sv
// ---------------------------------------------------------------------------
// ud_counter_pkg
// Shared constants and helpers for the modulo up/down counter.
//   UP / DOWN          : encodings of the UD direction input
//   MODE_WRAP/MODE_SAT : encodings of the SAT mode input
//   sum_w()            : width of the internal sums (counter width + 1), so
//                        that no step result can silently wrap mod 2^W
// ---------------------------------------------------------------------------
package ud_counter_pkg;

  localparam logic UP        = 1'b1;
  localparam logic DOWN      = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic int sum_w(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/ud_step_alu.sv
// ---------------------------------------------------------------------------
// ud_step_alu
// Purely combinational next-value computation for one count step.
// Ports:
//   Q     [W-1:0]  in  current count
//   STEP  [SW-1:0] in  step magnitude
//   LIMIT [W-1:0]  in  top of the count range 0..LIMIT
//   UD             in  1 = up, 0 = down
//   SAT            in  1 = saturate, 0 = wrap
//   NQ    [W-1:0]  out count after this step
//   BND            out boundary event (wrap, saturate or illegal-state clamp)
// ---------------------------------------------------------------------------
module ud_step_alu
  import ud_counter_pkg::*;
#(
  parameter int W  = 4,
  parameter int SW = 2
) (
  input  logic [W-1:0]  Q,
  input  logic [SW-1:0] STEP,
  input  logic [W-1:0]  LIMIT,
  input  logic          UD,
  input  logic          SAT,
  output logic [W-1:0]  NQ,
  output logic          BND
);

  localparam int XW = sum_w(W);

  // Wrapped result going up: the excess above LIMIT re-enters at 0.
  function automatic logic [W-1:0] wrap_up(input logic [XW-1:0] sum,
                                           input logic [XW-1:0] lim1);
    logic [XW-1:0] r;
    r = sum - lim1;
    return r[W-1:0];
  endfunction

  // Wrapped result going down: the deficit below 0 re-enters at LIMIT.
  function automatic logic [W-1:0] wrap_dn(input logic [XW-1:0] qx,
                                           input logic [XW-1:0] lim1,
                                           input logic [XW-1:0] sx);
    logic [XW-1:0] r;
    r = qx + lim1 - sx;
    return r[W-1:0];
  endfunction

  // Saturated result: pinned to the boundary in the direction of travel.
  function automatic logic [W-1:0] sat_edge(input logic ud,
                                            input logic [W-1:0] lim);
    return (ud == UP) ? lim : '0;
  endfunction

  logic [XW-1:0] qx;
  logic [XW-1:0] sx;
  logic [XW-1:0] lim;
  logic [XW-1:0] lim1;
  logic [XW-1:0] sum;

  always_comb begin
    qx   = {1'b0, Q};
    sx   = XW'(STEP);
    lim  = {1'b0, LIMIT};
    lim1 = lim + XW'(1);
    sum  = qx + sx;
    NQ   = Q;
    BND  = 1'b0;
    if (sx == '0) begin
      // Zero step: hold, never a boundary event.
      NQ  = Q;
      BND = 1'b0;
    end else if ((qx > lim) || ((SAT == MODE_WRAP) && (sx > lim1))) begin
      // Out-of-range count (LIMIT lowered mid-count) or a wrap step larger
      // than the whole range: no meaningful wrap exists, so clamp.
      NQ  = sat_edge(UD, LIMIT);
      BND = 1'b1;
    end else if (UD == UP) begin
      if (sum <= lim) begin
        NQ = sum[W-1:0];
      end else begin
        BND = 1'b1;
        NQ  = (SAT == MODE_SAT) ? sat_edge(UD, LIMIT) : wrap_up(sum, lim1);
      end
    end else begin
      if (sx <= qx) begin
        NQ = Q - sx[W-1:0];
      end else begin
        BND = 1'b1;
        NQ  = (SAT == MODE_SAT) ? sat_edge(UD, LIMIT) : wrap_dn(qx, lim1, sx);
      end
    end
  end

endmodule

// File: rtl/ud_counter_mod.sv
// ---------------------------------------------------------------------------
// ud_counter_mod
// Modulo up/down counter with runtime LIMIT, programmable STEP, wrap or
// saturate mode, terminal count, carry/borrow pulse and sticky overflow.
// Optional build macro: UD_COUNTER_PRESCALE_EN -- divides CE by PRESCALE so
// a count step happens only on every PRESCALE-th enabled cycle.
// Ports:
//   CLK            in  rising-edge clock
//   RST_N          in  asynchronous active-low reset
//   CLR            in  synchronous clear (highest priority)
//   CE             in  count enable
//   LD             in  synchronous load (does not need CE)
//   D     [W-1:0]  in  load value
//   UD             in  1 = up, 0 = down
//   STEP  [SW-1:0] in  step magnitude
//   LIMIT [W-1:0]  in  count range 0..LIMIT
//   SAT            in  1 = saturate, 0 = wrap
//   Q     [W-1:0]  out registered count
//   TC             out combinational terminal count / cascade enable
//   CO             out registered one-cycle boundary event pulse
//   OVF            out registered sticky boundary/clamp flag
// ---------------------------------------------------------------------------
module ud_counter_mod
  import ud_counter_pkg::*;
#(
  parameter int W        = 4,
  parameter int SW       = 2,
  parameter int PRESCALE = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CLR,
  input  logic          CE,
  input  logic          LD,
  input  logic [W-1:0]  D,
  input  logic          UD,
  input  logic [SW-1:0] STEP,
  input  logic [W-1:0]  LIMIT,
  input  logic          SAT,
  output logic [W-1:0]  Q,
  output logic          TC,
  output logic          CO,
  output logic          OVF
);

  if (PRESCALE < 1) begin : g_prescale_check
    $error("ud_counter_mod: PRESCALE must be >= 1");
  end

  logic [W-1:0] q_p1;
  logic         co_p1;
  logic         ovf_p1;
  logic [W-1:0] alu_q;
  logic         alu_bnd;
  logic         step_en;
  logic         psc_tc;

  ud_step_alu #(
    .W  (W),
    .SW (SW)
  ) u_alu (
    .Q     (q_p1),
    .STEP  (STEP),
    .LIMIT (LIMIT),
    .UD    (UD),
    .SAT   (SAT),
    .NQ    (alu_q),
    .BND   (alu_bnd)
  );

`ifdef UD_COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] psc_p1;

  assign psc_tc = (psc_p1 == PW'(PRESCALE - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      psc_p1 <= '0;
    end else if (CLR || LD) begin
      psc_p1 <= '0;
    end else if (CE) begin
      psc_p1 <= psc_tc ? '0 : psc_p1 + PW'(1);
    end
  end
`else
  assign psc_tc = 1'b1;
`endif

  assign step_en = CE && psc_tc;

  // ---- input -> registered count/flags (one cycle) ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_p1   <= '0;
      co_p1  <= 1'b0;
      ovf_p1 <= 1'b0;
    end else if (CLR) begin
      q_p1   <= '0;
      co_p1  <= 1'b0;
      ovf_p1 <= 1'b0;
    end else if (LD) begin
      co_p1 <= 1'b0;
      if (D > LIMIT) begin
        // Out-of-range load is clamped and flagged.
        q_p1   <= LIMIT;
        ovf_p1 <= 1'b1;
      end else begin
        q_p1   <= D;
        ovf_p1 <= 1'b0;
      end
    end else if (step_en) begin
      q_p1   <= alu_q;
      co_p1  <= alu_bnd;
      ovf_p1 <= ovf_p1 | alu_bnd;
    end else begin
      co_p1 <= 1'b0;
    end
  end

  assign Q   = q_p1;
  assign CO  = co_p1;
  assign OVF = ovf_p1;
  assign TC  = step_en &&
               (((UD == UP) && (q_p1 == LIMIT)) || ((UD == DOWN) && (q_p1 == '0)));

endmodule

// File: tb/tb_ud_counter_mod.sv
module tb_ud_counter_mod;

  logic       CLK;
  logic       RST_N;
  logic       CLR;
  logic       CE;
  logic       LD;
  logic [3:0] D;
  logic       UD;
  logic [1:0] STEP;
  logic [3:0] LIMIT;
  logic       SAT;

  logic [3:0] q1;
  logic       tc1, co1, ovf1;
  logic [3:0] q3;
  logic       tc3, co3, ovf3;

  int n_chk;
  int n_pass;

  ud_counter_mod #(.W(4), .SW(2), .PRESCALE(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .CE(CE), .LD(LD), .D(D),
    .UD(UD), .STEP(STEP), .LIMIT(LIMIT), .SAT(SAT),
    .Q(q1), .TC(tc1), .CO(co1), .OVF(ovf1)
  );

  ud_counter_mod #(.W(4), .SW(2), .PRESCALE(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .CE(CE), .LD(LD), .D(D),
    .UD(UD), .STEP(STEP), .LIMIT(LIMIT), .SAT(SAT),
    .Q(q3), .TC(tc3), .CO(co3), .OVF(ovf3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [3:0] q, input logic co, input logic ovf);
    chk({tag, ".Q"}, 8'(q1), 8'(q));
    chk({tag, ".CO"}, 8'(co1), 8'(co));
    chk({tag, ".OVF"}, 8'(ovf1), 8'(ovf));
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    RST_N = 1'b1; CLR = 1'b0; CE = 1'b0; LD = 1'b0; D = 4'd0;
    UD = 1'b1; STEP = 2'd1; LIMIT = 4'd15; SAT = 1'b0;
    #2 RST_N = 1'b0;
    tick();
    tick();
    chk3("reset", 4'd0, 1'b0, 1'b0);
    chk("reset.TC", 8'(tc1), 8'd0);

    // 1: count to 7, then asynchronous reset mid-cycle
    RST_N = 1'b1;
    CE = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk3("t1.count7", 4'd7, 1'b0, 1'b0);
    #2 RST_N = 1'b0;
    #1;
    chk3("t1.async_rst", 4'd0, 1'b0, 1'b0);
    CE = 1'b0;
    RST_N = 1'b1;
    tick();
    chk3("t1.release", 4'd0, 1'b0, 1'b0);

    // 2: up wrap at LIMIT=9
    LIMIT = 4'd9; STEP = 2'd1; UD = 1'b1; SAT = 1'b0;
    LD = 1'b1; D = 4'd8;
    tick();
    chk3("t2.load8", 4'd8, 1'b0, 1'b0);
    LD = 1'b0; CE = 1'b1;
    tick();
    chk3("t2.q9", 4'd9, 1'b0, 1'b0);
    chk("t2.TC", 8'(tc1), 8'd1);
    tick();
    chk3("t2.wrap", 4'd0, 1'b1, 1'b1);
    chk("t2.TC_after", 8'(tc1), 8'd0);
    tick();
    chk3("t2.after", 4'd1, 1'b0, 1'b1);

    // 3: down wrap with STEP=3, then STEP=0 holds
    CE = 1'b0; LD = 1'b1; D = 4'd1;
    tick();
    chk3("t3.load1", 4'd1, 1'b0, 1'b0);
    LD = 1'b0; CE = 1'b1; UD = 1'b0; STEP = 2'd3;
    tick();
    chk3("t3.dnwrap", 4'd8, 1'b1, 1'b1);
    STEP = 2'd0;
    tick();
    chk3("t3.step0", 4'd8, 1'b0, 1'b1);

    // 4: saturate up at LIMIT=12, repeat, then step down
    CE = 1'b0; LIMIT = 4'd12; STEP = 2'd3; UD = 1'b1; SAT = 1'b1;
    LD = 1'b1; D = 4'd10;
    tick();
    chk3("t4.load10", 4'd10, 1'b0, 1'b0);
    LD = 1'b0; CE = 1'b1;
    tick();
    chk3("t4.sat1", 4'd12, 1'b1, 1'b1);
    tick();
    chk3("t4.sat2", 4'd12, 1'b1, 1'b1);
    UD = 1'b0;
    tick();
    chk3("t4.down", 4'd9, 1'b0, 1'b1);

    // saturate down below 0
    STEP = 2'd3; LD = 1'b1; D = 4'd2; CE = 1'b0;
    tick();
    LD = 1'b0; CE = 1'b1;
    tick();
    chk3("sat_dn", 4'd0, 1'b1, 1'b1);
    chk("sat_dn.TC", 8'(tc1), 8'd1);

    // 5: clamped load, then CLR beats LD
    CE = 1'b0; LIMIT = 4'd9; LD = 1'b1; D = 4'd14;
    tick();
    chk3("t5.ldclamp", 4'd9, 1'b0, 1'b1);
    CLR = 1'b1; D = 4'd5;
    tick();
    chk3("t5.clr_ld", 4'd0, 1'b0, 1'b0);
    CLR = 1'b0; LD = 1'b0;

    // LIMIT = 0: every nonzero step is a boundary event
    LIMIT = 4'd0; SAT = 1'b0; UD = 1'b1; STEP = 2'd1; CE = 1'b1;
    tick();
    chk3("lim0.up", 4'd0, 1'b1, 1'b1);
    UD = 1'b0; STEP = 2'd2;
    tick();
    chk3("lim0.dn", 4'd0, 1'b1, 1'b1);

    // Q above a lowered LIMIT clamps to 0 going down
    CE = 1'b0; LIMIT = 4'd15; LD = 1'b1; D = 4'd13;
    tick();
    chk3("ill.load13", 4'd13, 1'b0, 1'b0);
    LD = 1'b0; LIMIT = 4'd5; UD = 1'b0; STEP = 2'd1; CE = 1'b1;
    tick();
    chk3("ill.clamp", 4'd0, 1'b1, 1'b1);

    // CE low holds Q and OVF, drops CO
    CE = 1'b0;
    tick();
    chk3("hold", 4'd0, 1'b0, 1'b1);

    // 6: prescaled instance vs. undivided instance
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk("t6.clr3", 8'(q3), 8'd0);
    LIMIT = 4'd15; STEP = 2'd1; UD = 1'b1; SAT = 1'b0; CE = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("t6.q1_e%0d", k), 8'(q1), 8'(k));
`ifdef UD_COUNTER_PRESCALE_EN
      chk($sformatf("t6.q3_e%0d", k), 8'(q3), 8'(k / 3));
`else
      chk($sformatf("t6.q3_e%0d", k), 8'(q3), 8'(k));
`endif
    end
    CE = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
